// File: rtl/debounce_toggle_bank.sv
// Multi-channel switch conditioner: two-flop synchroniser, counter debounce,
// registered edge pulses, clearable toggle latch and optional long-press pulse.
module debounce_toggle_bank #(
  parameter int N          = 4,
  parameter int STABLE     = 19,
  parameter int ACTIVE_LOW = 0,
  parameter int LONG       = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw_in,
  input  logic [N-1:0] toggle_clr,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] toggle,
  output logic [N-1:0] long_press
);

  localparam int            CW       = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);
  localparam logic [N-1:0]  POL_MASK = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

  logic [N-1:0] w_x;
  logic [N-1:0] r_sync_p0;
  logic [N-1:0] r_sync_p1;

  assign w_x = sw_in ^ POL_MASK;

  // Stage 0/1: polarity-corrected input through a two-flop synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= w_x;
      r_sync_p1 <= r_sync_p0;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic          w_s;
    logic          w_accept;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic          r_toggle;

    assign w_s      = r_sync_p1[g];
    assign w_accept = (w_s != r_level) && (r_cnt == CNT_LAST);

    // Stage 2: acceptance updates level, edge pulses and toggle on one edge
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt    <= '0;
        r_level  <= 1'b0;
        r_rise   <= 1'b0;
        r_fall   <= 1'b0;
        r_toggle <= 1'b0;
      end else begin
        r_rise <= w_accept && w_s;
        r_fall <= w_accept && !w_s;
        if (w_s == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_level <= w_s;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        // A clear in the acceptance cycle wins over the flip
        if (toggle_clr[g]) begin
          r_toggle <= 1'b0;
        end else if (w_accept && w_s) begin
          r_toggle <= !r_toggle;
        end
      end
    end

    assign level[g]  = r_level;
    assign rise[g]   = r_rise;
    assign fall[g]   = r_fall;
    assign toggle[g] = r_toggle;

    if (LONG > 0) begin : g_long
      localparam int            HW      = $clog2(LONG + 1);
      localparam logic [HW-1:0] HC_MAX  = HW'(LONG);
      localparam logic [HW-1:0] HC_LAST = HW'(LONG - 1);

      logic [HW-1:0] r_hc;
      logic          r_long;

      function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
        return (v == HC_MAX) ? v : v + 1'b1;
      endfunction

      // Stage 3: hold counter saturates so the pulse fires once per press
      always_ff @(posedge clk) begin
        if (rst) begin
          r_hc   <= '0;
          r_long <= 1'b0;
        end else begin
          r_long <= r_level && (r_hc == HC_LAST);
          if (!r_level || (w_accept && !w_s)) begin
            r_hc <= '0;
          end else begin
            r_hc <= sat_inc(r_hc);
          end
        end
      end

      assign long_press[g] = r_long;
    end else begin : g_nolong
      assign long_press[g] = 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_toggle_bank.sv
// Directed bench for debounce_toggle_bank: an active-high instance with long-press
// detection and an active-low instance without it, both with STABLE=4.
module tb_debounce_toggle_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] swA, clrA, lvlA, riseA, fallA, togA, lpA;
  logic [1:0] swB, clrB, lvlB, riseB, fallB, togB, lpB;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_lp, cnt_rise, cnt_fall, cnt_lvl;

  always #5 clk = ~clk;

  debounce_toggle_bank #(.N(2), .STABLE(4), .ACTIVE_LOW(0), .LONG(10)) u_a (
    .clk(clk), .rst(rst), .sw_in(swA), .toggle_clr(clrA),
    .level(lvlA), .rise(riseA), .fall(fallA), .toggle(togA), .long_press(lpA)
  );

  debounce_toggle_bank #(.N(2), .STABLE(4), .ACTIVE_LOW(1), .LONG(0)) u_b (
    .clk(clk), .rst(rst), .sw_in(swB), .toggle_clr(clrB),
    .level(lvlB), .rise(riseB), .fall(fallB), .toggle(togB), .long_press(lpB)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    swA  = 2'b11;
    swB  = 2'b11;
    clrA = 2'b00;
    clrB = 2'b00;

    // reset held three cycles with inputs active on A, idle-high on B
    tick(1);
    chk("rst1_A", {lvlA, riseA, fallA, togA, lpA}, 0);
    chk("rst1_B", {lvlB, riseB, fallB, togB, lpB}, 0);
    tick(2);
    chk("rst3_A", {lvlA, riseA, fallA, togA, lpA}, 0);
    chk("rst3_B", {lvlB, riseB, fallB, togB, lpB}, 0);

    // re-acceptance of held inputs after release: level after E0+5
    rst = 1'b0;
    tick(5);
    chk("rel_lvl_E4", lvlA, 2'b00);
    tick(1);
    chk("rel_lvl_E5", lvlA, 2'b11);
    chk("rel_rise_E5", riseA, 2'b11);
    chk("rel_fall_E5", fallA, 2'b00);
    chk("rel_tog_E5", togA, 2'b11);
    chk("B_idle_lvl", lvlB, 2'b00);
    chk("B_idle_rise", riseB, 2'b00);
    tick(1);
    chk("rel_rise_E6", riseA, 2'b00);
    chk("rel_lvl_E6", lvlA, 2'b11);

    // long press: pulse in the cycle after Er+10, exactly once
    tick(8);
    chk("lp_Er9", lpA, 2'b00);
    tick(1);
    chk("lp_Er10", lpA, 2'b11);
    tick(1);
    chk("lp_Er11", lpA, 2'b00);
    cnt_lp = 0;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      if (lpA != 2'b00) cnt_lp++;
    end
    chk("lp_no_repeat", cnt_lp, 0);
    chk("lp_hold_lvl", lvlA, 2'b11);

    // release both channels
    swA = 2'b00;
    tick(5);
    chk("relA_lvl_E4", lvlA, 2'b11);
    tick(1);
    chk("relA_lvl_E5", lvlA, 2'b00);
    chk("relA_fall_E5", fallA, 2'b11);
    chk("relA_rise_E5", riseA, 2'b00);
    chk("relA_tog_E5", togA, 2'b11);
    tick(1);
    chk("relA_fall_E6", fallA, 2'b00);

    // 3-cycle glitch on ch0 is rejected
    swA = 2'b01;
    tick(3);
    swA = 2'b00;
    cnt_rise = 0;
    cnt_lvl  = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (riseA[0]) cnt_rise++;
      if (lvlA[0]) cnt_lvl++;
    end
    chk("glitch_rise", cnt_rise, 0);
    chk("glitch_lvl", cnt_lvl, 0);

    // 4-cycle press is accepted with full latency
    swA = 2'b01;
    tick(4);
    swA = 2'b00;
    tick(1);
    chk("p4_lvl_E4", lvlA, 2'b00);
    tick(1);
    chk("p4_lvl_E5", lvlA, 2'b01);
    chk("p4_rise_E5", riseA, 2'b01);
    chk("p4_tog_E5", togA, 2'b10);
    tick(3);
    chk("p4_lvl_E8", lvlA, 2'b01);
    chk("p4_rise_E8", riseA, 2'b00);
    tick(1);
    chk("p4_lvl_E9", lvlA, 2'b00);
    chk("p4_fall_E9", fallA, 2'b01);

    // level held 9 cycles: no long-press pulse
    swA      = 2'b01;
    cnt_lp   = 0;
    cnt_rise = 0;
    cnt_fall = 0;
    for (int i = 0; i < 29; i++) begin
      if (i == 9) swA = 2'b00;
      tick(1);
      if (lpA[0]) cnt_lp++;
      if (riseA[0]) cnt_rise++;
      if (fallA[0]) cnt_fall++;
    end
    chk("lp9_pulses", cnt_lp, 0);
    chk("lp9_rises", cnt_rise, 1);
    chk("lp9_falls", cnt_fall, 1);
    chk("lp9_tog", togA, 2'b11);

    // idle clear of ch1 toggle
    clrA = 2'b10;
    tick(1);
    clrA = 2'b00;
    chk("clr_tog", togA, 2'b01);
    chk("clr_lvl", lvlA, 2'b00);

    // three clean presses on ch1
    swA = 2'b10;
    tick(6);
    chk("t1_lvl", lvlA, 2'b10);
    chk("t1_rise", riseA, 2'b10);
    chk("t1_tog", togA, 2'b11);
    swA = 2'b00;
    tick(6);
    chk("t1_fall", {lvlA, fallA}, 4'b0010);
    chk("t1_tog_rel", togA, 2'b11);
    swA = 2'b10;
    tick(6);
    chk("t2_rise", {lvlA, riseA}, 4'b1010);
    chk("t2_tog", togA, 2'b01);
    swA = 2'b00;
    tick(6);
    chk("t2_fall", {lvlA, fallA}, 4'b0010);
    swA = 2'b10;
    tick(5);
    clrA = 2'b10;
    tick(1);
    clrA = 2'b00;
    chk("t3_rise", {lvlA, riseA}, 4'b1010);
    chk("t3_tog_clr", togA, 2'b01);
    swA = 2'b00;
    tick(6);
    chk("t3_fall", {lvlA, fallA}, 4'b0010);

    // active-low instance: pulled low 6 cycles on ch0
    swB = 2'b10;
    tick(6);
    chk("al_lvl", lvlB, 2'b01);
    chk("al_rise", riseB, 2'b01);
    chk("al_tog", togB, 2'b01);
    swB = 2'b11;
    tick(5);
    chk("al_lvl_hold", {lvlB, fallB}, 4'b0100);
    tick(1);
    chk("al_fall", {lvlB, fallB}, 4'b0001);
    chk("al_lp", lpB, 2'b00);

    // independence: ch1 offset by one cycle, then simultaneous edges
    swA = 2'b01;
    tick(1);
    swA = 2'b11;
    tick(5);
    chk("ind_ch0_rise", {lvlA, riseA}, 4'b0101);
    chk("ind_ch0_tog", togA, 2'b00);
    swA = 2'b10;
    tick(1);
    chk("ind_ch1_rise", {lvlA, riseA}, 4'b1110);
    chk("ind_ch1_tog", togA, 2'b10);
    swA = 2'b00;
    tick(4);
    chk("ind_hold", {lvlA, fallA}, 4'b1100);
    tick(1);
    chk("ind_ch0_fall", {lvlA, fallA}, 4'b1001);
    tick(1);
    chk("ind_ch1_fall", {lvlA, fallA}, 4'b0010);
    swA = 2'b11;
    tick(6);
    chk("sim_rise", {lvlA, riseA, fallA}, 6'b111100);
    chk("sim_tog", togA, 2'b01);
    swA = 2'b00;
    tick(6);
    chk("sim_fall", {lvlA, riseA, fallA}, 6'b000011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
